// File: rtl/rx_boxcar_decimator.sv
// rx_boxcar_decimator
//   First-order boxcar (CIC order 1) decimator for the RX I/Q stream.
//   R consecutive signed samples are summed per lane, and one 64-bit sum is
//   emitted for every R input samples. The sums pass through a small output
//   FIFO that honours AXI-stream backpressure.
//
//   Build option: define RX_BOXCAR_OVF_COUNT_EN to add ovf_count_o, a
//   saturating count of dropped sums.
//
// Ports
//   clk                  clock
//   rst_n                asynchronous active-low reset
//   rate_axis_tdata_i    decimation factor R (0 or 1 selects pass-through)
//   rate_axis_tvalid_i   rate write strobe
//   rx_iq_axis_tdata_i   {q[31:16], i[15:0]} signed input sample
//   rx_iq_axis_tvalid_i  input sample valid
//   axis_tdata_o         {q_sum[63:32], i_sum[31:0]} signed output sum
//   axis_tvalid_o        output FIFO non-empty
//   axis_tready_i        consumer ready
//   rate_o               last written rate value
//   ovf_o                sticky flag: a sum was dropped on a full FIFO
//   ovf_count_o          number of dropped sums, saturating (option only)
module rx_boxcar_decimator #(
  parameter int FIFO_DEPTH = 4,
  parameter int INIT_RATE  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rate_axis_tdata_i,
  input  logic        rate_axis_tvalid_i,
  input  logic [31:0] rx_iq_axis_tdata_i,
  input  logic        rx_iq_axis_tvalid_i,
  output logic [63:0] axis_tdata_o,
  output logic        axis_tvalid_o,
  input  logic        axis_tready_i,
  output logic [15:0] rate_o,
  output logic        ovf_o
`ifdef RX_BOXCAR_OVF_COUNT_EN
  ,
  output logic [15:0] ovf_count_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {WAIT_RATE, ACCUM} state_t;

  function automatic logic signed [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t             state, state_nxt;
  logic        [15:0] rate_q;
  logic        [15:0] r_eff;
  logic        [15:0] cnt_p0;
  logic signed [31:0] acc_i_p0, acc_q_p0;
  logic signed [31:0] sum_i, sum_q;
  logic               rate_wr, take, dump_vld_p0;

  logic [63:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               empty, full, pop, push_ok, drop;

  assign rate_wr = rate_axis_tvalid_i;
  assign r_eff   = (rate_q <= 16'd1) ? 16'd1 : rate_q;
  // The sum includes the current sample, so the dump needs no extra cycle.
  assign sum_i   = acc_i_p0 + sext16(rx_iq_axis_tdata_i[15:0]);
  assign sum_q   = acc_q_p0 + sext16(rx_iq_axis_tdata_i[31:16]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= (INIT_RATE == 0) ? WAIT_RATE : ACCUM;
    else        state <= state_nxt;
  end

  // A rate write wins over a sample arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      WAIT_RATE: if (rate_wr) state_nxt = ACCUM;
      ACCUM:     take = rx_iq_axis_tvalid_i && !rate_wr;
      default:   state_nxt = WAIT_RATE;
    endcase
  end

  assign dump_vld_p0 = take && (cnt_p0 == r_eff - 16'd1);

  // ---- stage p0: accumulate ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_q   <= 16'(INIT_RATE);
      cnt_p0   <= '0;
      acc_i_p0 <= '0;
      acc_q_p0 <= '0;
    end else if (rate_wr) begin
      rate_q   <= rate_axis_tdata_i;
      cnt_p0   <= '0;
      acc_i_p0 <= '0;
      acc_q_p0 <= '0;
    end else if (take) begin
      if (dump_vld_p0) begin
        cnt_p0   <= '0;
        acc_i_p0 <= '0;
        acc_q_p0 <= '0;
      end else begin
        cnt_p0   <= cnt_p0 + 16'd1;
        acc_i_p0 <= sum_i;
        acc_q_p0 <= sum_q;
      end
    end
  end

  // ---- stage p1: output FIFO ----
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = !empty && axis_tready_i;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign drop    = dump_vld_p0 && full && !pop;
  assign push_ok = dump_vld_p0 && !drop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {sum_q, sum_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rate_wr)   ovf_o <= 1'b0;
      else if (drop) ovf_o <= 1'b1;
    end
  end

`ifdef RX_BOXCAR_OVF_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_count_o <= '0;
    else if (rate_wr) ovf_count_o <= '0;
    else if (drop)    ovf_count_o <= sat_inc16(ovf_count_o);
  end
`endif

  // Memory is not reset; masking the read keeps the data output at zero
  // whenever nothing is queued.
  assign axis_tdata_o  = empty ? '0 : mem[rd_ptr];
  assign axis_tvalid_o = !empty;
  assign rate_o        = rate_q;

endmodule

// File: tb/tb_rx_boxcar_decimator.sv
module tb_rx_boxcar_decimator;

  localparam int DEPTH = 4;
  localparam int INIT  = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rate_d = '0;
  logic        rate_v = 1'b0;
  logic [31:0] iq_d = '0;
  logic        iq_v = 1'b0;
  logic        tready = 1'b0;
  logic [63:0] tdata;
  logic        tvalid;
  logic [15:0] rate_o;
  logic        ovf;
`ifdef RX_BOXCAR_OVF_COUNT_EN
  logic [15:0] ovf_cnt;
`endif

  rx_boxcar_decimator #(.FIFO_DEPTH(DEPTH), .INIT_RATE(INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rate_axis_tdata_i(rate_d), .rate_axis_tvalid_i(rate_v),
    .rx_iq_axis_tdata_i(iq_d), .rx_iq_axis_tvalid_i(iq_v),
    .axis_tdata_o(tdata), .axis_tvalid_o(tvalid), .axis_tready_i(tready),
    .rate_o(rate_o), .ovf_o(ovf)
`ifdef RX_BOXCAR_OVF_COUNT_EN
    , .ovf_count_o(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_rate = INIT;
  bit          m_have = (INIT != 0);
  int          part_i[$];
  int          part_q[$];
  logic [63:0] mq[$];
  bit          m_ovf = 0;
  int          m_drops = 0;
  logic [63:0] seen[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rate = INIT; m_have = (INIT != 0);
      part_i.delete(); part_q.delete(); mq.delete();
      m_ovf = 0; m_drops = 0;
    end else begin
      bit m_pop, m_push;
      logic [63:0] val;
      m_pop  = (mq.size() > 0) && tready;
      m_push = 0;
      val    = '0;
      if (rate_v) begin
        m_rate = int'(rate_d); m_have = 1;
        part_i.delete(); part_q.delete();
        m_ovf = 0; m_drops = 0;
      end else if (m_have && iq_v) begin
        logic signed [15:0] si, sq;
        int reff, s_i, s_q;
        si = iq_d[15:0]; sq = iq_d[31:16];
        part_i.push_back(int'(si)); part_q.push_back(int'(sq));
        reff = (m_rate <= 1) ? 1 : m_rate;
        if (part_i.size() == reff) begin
          s_i = 0; s_q = 0;
          foreach (part_i[k]) begin s_i += part_i[k]; s_q += part_q[k]; end
          val = {32'(s_q), 32'(s_i)};
          m_push = 1;
          part_i.delete(); part_q.delete();
        end
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(val);
        else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
  end

  // Compare process: outputs are registered, so the falling edge is safe.
  always @(negedge clk) begin
    chk("tvalid", {63'd0, tvalid}, {63'd0, mq.size() > 0});
    if (mq.size() > 0) chk("tdata", tdata, mq[0]);
    if (!rst_n) chk("tdata_rst", tdata, 64'd0);
    chk("ovf", {63'd0, ovf}, {63'd0, m_ovf});
    chk("rate_o", {48'd0, rate_o}, 64'(m_rate));
`ifdef RX_BOXCAR_OVF_COUNT_EN
    chk("ovf_count", {48'd0, ovf_cnt}, 64'(m_drops));
`endif
    if (rst_n && tvalid && tready) seen.push_back(tdata);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic rv, input logic [15:0] rd, input logic sv,
                     input logic [15:0] si, input logic [15:0] sq, input logic tr);
    rate_v = rv; rate_d = rd; iq_v = sv; iq_d = {sq, si}; tready = tr;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n, input logic tr);
    for (int k = 0; k < n; k++) cyc(0, 16'd0, 0, 16'd0, 16'd0, tr);
  endtask

  initial begin
    int b;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_tvalid", {63'd0, tvalid}, 64'd0);
    chk("reset_ovf", {63'd0, ovf}, 64'd0);
    chk("reset_rate", {48'd0, rate_o}, 64'd0);
    rst_n = 1'b1;

    // 1: waiting for a rate, then R=4
    for (int k = 1; k <= 10; k++) cyc(0, 16'd0, 1, 16'(k), 16'(-k), 1);
    idle(2, 1);
    chk("t1_wait_none", 64'(seen.size()), 64'd0);
    cyc(1, 16'd4, 0, 16'd0, 16'd0, 1);
    for (int k = 1; k <= 8; k++) cyc(0, 16'd0, 1, 16'(k), 16'(-k), 1);
    idle(3, 1);
    chk("t1_count", 64'(seen.size()), 64'd2);
    if (seen.size() >= 2) begin
      chk("t1_out0", seen[0], 64'hFFFFFFF6_0000000A);
      chk("t1_out1", seen[1], 64'hFFFFFFE6_0000001A);
    end

    // 2: pass-through, one output per cycle
    cyc(1, 16'd1, 0, 16'd0, 16'd0, 1);
    b = seen.size();
    cyc(0, 16'd0, 1, 16'h7FFF, 16'h8000, 1);
    chk("t2_latency_vld", {63'd0, tvalid}, 64'd1);
    chk("t2_latency_dat", tdata, 64'hFFFF8000_00007FFF);
    for (int k = 0; k < 5; k++) cyc(0, 16'd0, 1, 16'h7FFF, 16'h8000, 1);
    idle(2, 1);
    chk("t2_count", 64'(seen.size() - b), 64'd6);
    if (seen.size() > 0) chk("t2_last", seen[seen.size()-1], 64'hFFFF8000_00007FFF);

    // 3: maximum rate, most negative samples
    cyc(1, 16'd65535, 0, 16'd0, 16'd0, 1);
    b = seen.size();
    for (int k = 0; k < 65535; k++) cyc(0, 16'd0, 1, 16'h8000, 16'h8000, 1);
    idle(2, 1);
    chk("t3_count", 64'(seen.size() - b), 64'd1);
    if (seen.size() > b) chk("t3_sum", seen[b], 64'h80008000_80008000);

    // 4: stalled FIFO overflow, then drain
    cyc(1, 16'd2, 0, 16'd0, 16'd0, 0);
    for (int k = 1; k <= 12; k++) cyc(0, 16'd0, 1, 16'(k), 16'(2*k), 0);
    idle(3, 0);
    chk("t4_ovf", {63'd0, ovf}, 64'd1);
    chk("t4_head", tdata, 64'h00000006_00000003);
`ifdef RX_BOXCAR_OVF_COUNT_EN
    chk("t4_ovf_count", {48'd0, ovf_cnt}, 64'd2);
`endif
    b = seen.size();
    idle(6, 1);
    chk("t4_pops", 64'(seen.size() - b), 64'd4);
    if (seen.size() >= b + 4) begin
      chk("t4_pop0", seen[b],   64'h00000006_00000003);
      chk("t4_pop1", seen[b+1], 64'h0000000E_00000007);
      chk("t4_pop2", seen[b+2], 64'h00000016_0000000B);
      chk("t4_pop3", seen[b+3], 64'h0000001E_0000000F);
    end

    // 5: rate write discards the partial sum and the concurrent sample
    cyc(1, 16'd3, 0, 16'd0, 16'd0, 1);
    cyc(0, 16'd0, 1, 16'd10, 16'd1, 1);
    cyc(0, 16'd0, 1, 16'd20, 16'd2, 1);
    b = seen.size();
    cyc(1, 16'd2, 1, 16'd100, 16'd7, 1);
    chk("t5_ovf_clr", {63'd0, ovf}, 64'd0);
    cyc(0, 16'd0, 1, 16'd5, 16'(-3), 1);
    cyc(0, 16'd0, 1, 16'd6, 16'(-4), 1);
    idle(2, 1);
    chk("t5_count", 64'(seen.size() - b), 64'd1);
    if (seen.size() > b) chk("t5_sum", seen[b], 64'hFFFFFFF9_0000000B);

    // 6: asynchronous reset with two entries queued and a partial sum
    for (int k = 1; k <= 5; k++) cyc(0, 16'd0, 1, 16'(k), 16'd1, 0);
    chk("t6_pre_vld", {63'd0, tvalid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_vld", {63'd0, tvalid}, 64'd0);
    chk("t6_async_dat", tdata, 64'd0);
    chk("t6_async_rate", {48'd0, rate_o}, 64'd0);
    idle(2, 1);
    rst_n = 1'b1;
    b = seen.size();
    for (int k = 1; k <= 5; k++) cyc(0, 16'd0, 1, 16'(k), 16'd1, 1);
    idle(2, 1);
    chk("t6_no_stale", 64'(seen.size() - b), 64'd0);
    cyc(1, 16'd1, 0, 16'd0, 16'd0, 1);
    cyc(0, 16'd0, 1, 16'd3, 16'd4, 1);
    idle(2, 1);
    chk("t6_after_count", 64'(seen.size() - b), 64'd1);
    if (seen.size() > b) chk("t6_after_dat", seen[b], 64'h00000004_00000003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
